multdiv_iter_unit: RTL and testbench

- Parametrised, iterative signed/unsigned multiply-divide unit for the CPU execute stage.
- Generalises the fixed 32-bit HI/LO unit to WIDTH bits and adds:
  - unsigned ops;
  - a configurable multiply step (bits retired per cycle);
  - a start/done handshake;
  - flush;
  - defined divide-by-zero and overflow results.
- Results land in internal HI/LO registers. The pipeline reads them via hi_o/lo_o; the stall is derived from busy_o.

---
 rtl/multdiv_iter_unit.sv | 257 +++++++++++++++++++++++++
 tb/tb_multdiv_iter_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_iter_unit.sv
// multdiv_iter_unit: iterative signed/unsigned multiply-divide unit with
// internal HI/LO result registers, start/done handshake and flush.
// WIDTH must be even and >= 4; MUL_STEP must be 1, 2 or 4 and divide WIDTH.
module multdiv_iter_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dz_o
);

  localparam int CW = $clog2(WIDTH);
  localparam int DW = 2 * WIDTH;
  localparam logic [CW-1:0]    MUL_LAST = CW'(WIDTH / MUL_STEP - 1);
  localparam logic [CW-1:0]    DIV_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES     = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;
  logic   accept;
  logic   commit;

  // Iteration state
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    acc;       // product accumulator, or preloaded special result
  logic [DW-1:0]    mcand;     // multiplicand magnitude, shifted left each step
  logic [WIDTH-1:0] mplier;    // multiplier magnitude, shifted right each step
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;      // holds the dividend, replaced by quotient bits
  logic             neg_prod;
  logic             neg_quot;
  logic             neg_rem;
  logic             use_div;   // FIX takes HI/LO from rem/quot instead of acc
  logic             pend_dz;

  // Committed architectural state
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dz;
  logic             done;

  // Operand decode at accept
  logic             div_op;
  logic             is_signed;
  logic             s1;
  logic             s2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic             div_zero;
  logic             div_ovf;
  logic             div_special;

  assign div_op      = op_i[1];
  assign is_signed   = ~op_i[0];
  assign s1          = is_signed & op1_i[WIDTH-1];
  assign s2          = is_signed & op2_i[WIDTH-1];
  // Negating MIN yields MIN, which is the correct unsigned magnitude.
  assign mag1        = s1 ? -op1_i : op1_i;
  assign mag2        = s2 ? -op2_i : op2_i;
  assign div_zero    = (op2_i == '0);
  assign div_ovf     = (op_i == 2'b10) && (op1_i == MIN_VAL) && (op2_i == ONES);
  assign div_special = div_zero | div_ovf;

  // Multiply step: one partial product per retired multiplier bit
  logic [DW-1:0] pp [MUL_STEP];
  logic [DW-1:0] mul_sum;

  genvar gi;
  generate
    for (gi = 0; gi < MUL_STEP; gi++) begin : g_pp
      assign pp[gi] = mplier[gi] ? (mcand << gi) : '0;
    end
  endgenerate

  // Sum this cycle's partial products into the running accumulator
  always_comb begin
    mul_sum = acc;
    for (int j = 0; j < MUL_STEP; j++) begin
      mul_sum = mul_sum + pp[j];
    end
  end

  // Restoring divide step: remainder never reaches the divisor, so it fits WIDTH bits
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quot_step;

  assign trial     = {rem, quot[WIDTH-1]} - {1'b0, divisor};
  assign fits      = ~trial[WIDTH];
  assign rem_step  = fits ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], quot[WIDTH-1]};
  assign quot_step = {quot[WIDTH-2:0], fits};

  // Sign correction applied in FIX
  logic [DW-1:0]    prod_fix;
  logic [WIDTH-1:0] hi_new;
  logic [WIDTH-1:0] lo_new;

  assign prod_fix = neg_prod ? -acc : acc;
  assign hi_new   = use_div ? (neg_rem  ? -rem  : rem)  : prod_fix[DW-1:WIDTH];
  assign lo_new   = use_div ? (neg_quot ? -quot : quot) : prod_fix[WIDTH-1:0];

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, accept/commit strobes and handshake outputs; flush overrides all
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    commit     = 1'b0;
    ready_o    = 1'b0;
    busy_o     = 1'b1;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
        if (start_i) begin
          accept = 1'b1;
          if (!div_op) begin
            state_next = MUL;
          end else if (div_special) begin
            state_next = FIX;
          end else begin
            state_next = DIV;
          end
        end
      end
      MUL: begin
        if (cnt == MUL_LAST) begin
          state_next = FIX;
        end
      end
      DIV: begin
        if (cnt == DIV_LAST) begin
          state_next = FIX;
        end
      end
      FIX: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (flush_i) begin
      state_next = IDLE;
      accept     = 1'b0;
      commit     = 1'b0;
    end
  end

  // Operand capture, iteration datapath and counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      divisor  <= '0;
      rem      <= '0;
      quot     <= '0;
      neg_prod <= 1'b0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      use_div  <= 1'b0;
      pend_dz  <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      mcand    <= {{WIDTH{1'b0}}, mag1};
      mplier   <= mag2;
      divisor  <= mag2;
      rem      <= '0;
      quot     <= mag1;
      neg_quot <= s1 ^ s2;
      neg_rem  <= s1;
      use_div  <= div_op & ~div_special;
      pend_dz  <= div_op & div_zero;
      // Special divides preload their final HI/LO and pass through FIX unchanged
      if (div_op && div_zero) begin
        acc      <= {op1_i, ONES};
        neg_prod <= 1'b0;
      end else if (div_op && div_ovf) begin
        acc      <= {{WIDTH{1'b0}}, MIN_VAL};
        neg_prod <= 1'b0;
      end else begin
        acc      <= '0;
        neg_prod <= s1 ^ s2;
      end
    end else if (state == MUL) begin
      acc    <= mul_sum;
      mcand  <= mcand << MUL_STEP;
      mplier <= mplier >> MUL_STEP;
      if (cnt != MUL_LAST) begin
        cnt <= cnt + CW'(1);
      end
    end else if (state == DIV) begin
      rem  <= rem_step;
      quot <= quot_step;
      if (cnt != DIV_LAST) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Committed HI/LO/dz and the one-cycle done pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi   <= '0;
      lo   <= '0;
      dz   <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= commit;
      if (accept) begin
        dz <= 1'b0;
      end
      if (commit) begin
        hi <= hi_new;
        lo <= lo_new;
        dz <= pend_dz;
      end
    end
  end

  assign done_o = done;
  assign hi_o   = hi;
  assign lo_o   = lo;
  assign dz_o   = dz;

endmodule

// File: tb/tb_multdiv_iter_unit.sv
// tb_multdiv_iter_unit: directed vectors for multdiv_iter_unit with a
// cycle-level reference model compared on every clock.
module tb_multdiv_iter_unit;

  localparam int MS = 2;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        start     = 1'b0;
  logic        flush     = 1'b0;
  logic        start_aux = 1'b0;
  logic        flush_aux = 1'b0;
  logic [1:0]  op        = 2'b00;
  logic [31:0] op1       = '0;
  logic [31:0] op2       = '0;

  logic        ready, busy, done, dz;
  logic [31:0] hi, lo;
  logic        ready1, busy1, done1, dz1;
  logic [31:0] hi1, lo1;
  logic        ready4, busy4, done4, dz4;
  logic [31:0] hi4, lo4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multdiv_iter_unit #(.WIDTH(32), .MUL_STEP(MS)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .op1_i(op1), .op2_i(op2),
    .flush_i(flush), .ready_o(ready), .busy_o(busy), .done_o(done),
    .hi_o(hi), .lo_o(lo), .dz_o(dz)
  );

  multdiv_iter_unit #(.WIDTH(32), .MUL_STEP(1)) u_s1 (
    .clk_i(clk), .rst_i(rst), .start_i(start_aux), .op_i(op), .op1_i(op1), .op2_i(op2),
    .flush_i(flush_aux), .ready_o(ready1), .busy_o(busy1), .done_o(done1),
    .hi_o(hi1), .lo_o(lo1), .dz_o(dz1)
  );

  multdiv_iter_unit #(.WIDTH(32), .MUL_STEP(4)) u_s4 (
    .clk_i(clk), .rst_i(rst), .start_i(start_aux), .op_i(op), .op1_i(op1), .op2_i(op2),
    .flush_i(flush_aux), .ready_o(ready4), .busy_o(busy4), .done_o(done4),
    .hi_o(hi4), .lo_o(lo4), .dz_o(dz4)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Arithmetic result and latency of one operation, straight from the op definitions
  function automatic void model_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] rhi, output logic [31:0] rlo,
                                     output logic rdz, output int rlat);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    int                 sa, sb;
    rdz = 1'b0;
    rhi = '0;
    rlo = '0;
    rlat = 32 + 2;
    case (o)
      2'b00: begin
        ps   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        rhi  = ps[63:32];
        rlo  = ps[31:0];
        rlat = 32 / MS + 2;
      end
      2'b01: begin
        pu   = {32'b0, a} * {32'b0, b};
        rhi  = pu[63:32];
        rlo  = pu[31:0];
        rlat = 32 / MS + 2;
      end
      2'b10: begin
        if (b == 32'h0) begin
          rhi = a; rlo = 32'hFFFF_FFFF; rdz = 1'b1; rlat = 2;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rhi = 32'h0; rlo = 32'h8000_0000; rlat = 2;
        end else begin
          sa  = a;
          sb  = b;
          rlo = sa / sb;
          rhi = sa % sb;
        end
      end
      default: begin
        if (b == 32'h0) begin
          rhi = a; rlo = 32'hFFFF_FFFF; rdz = 1'b1; rlat = 2;
        end else begin
          rlo = a / b;
          rhi = a % b;
        end
      end
    endcase
  endfunction

  // Reference model: busy countdown, pending result, committed HI/LO/dz
  logic        m_busy = 1'b0;
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_dz = 1'b0, p_dz = 1'b0, m_done = 1'b0;
  logic [31:0] t_hi, t_lo;
  logic        t_dz;
  int          t_lat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_left <= 0; m_hi <= '0; m_lo <= '0;
      m_dz <= 1'b0; m_done <= 1'b0; p_hi <= '0; p_lo <= '0; p_dz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (flush) begin
        m_busy <= 1'b0;
      end else if (!m_busy) begin
        if (start) begin
          model_calc(op, op1, op2, t_hi, t_lo, t_dz, t_lat);
          p_hi   <= t_hi;
          p_lo   <= t_lo;
          p_dz   <= t_dz;
          m_left <= t_lat - 1;
          m_busy <= 1'b1;
          m_dz   <= 1'b0;
        end
      end else begin
        if (m_left == 1) begin
          m_hi   <= p_hi;
          m_lo   <= p_lo;
          m_dz   <= p_dz;
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
        m_left <= m_left - 1;
      end
    end
  end

  // Compare every cycle, on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      check("cyc_ready", {31'b0, ready}, {31'b0, ~m_busy});
      check("cyc_busy",  {31'b0, busy},  {31'b0, m_busy});
      check("cyc_done",  {31'b0, done},  {31'b0, m_done});
      check("cyc_dz",    {31'b0, dz},    {31'b0, m_dz});
      check("cyc_hi",    hi, m_hi);
      check("cyc_lo",    lo, m_lo);
    end
  end

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    op1   = a;
    op2   = b;
    start = 1'b1;
  endtask

  task automatic wait_done(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input logic exp_dz, input int exp_lat);
    int cyc;
    for (cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        check({name, "_busy_at_accept"}, {31'b0, busy}, 32'd1);
        check({name, "_dz_clear"}, {31'b0, dz}, 32'd0);
      end
      if (done) break;
    end
    check({name, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
    check({name, "_dz"}, {31'b0, dz}, {31'b0, exp_dz});
    $display("txn %s op=%b a=%h b=%h -> hi=%h lo=%h dz=%b lat=%0d", name, op, op1, op2, hi, lo, dz, cyc);
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dz,
                     input int exp_lat);
    start_op(o, a, b);
    wait_done(name, exp_hi, exp_lo, exp_dz, exp_lat);
  endtask

  // MULTU all-ones squared on the MUL_STEP=1 and MUL_STEP=4 instances
  task automatic aux_run();
    int l1 = 0, l4 = 0;
    logic [31:0] h1 = '0, g1 = '0, h4 = '0, g4 = '0;
    op = 2'b01; op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF; start_aux = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) start_aux = 1'b0;
      if (done1 && l1 == 0) begin l1 = c; h1 = hi1; g1 = lo1; end
      if (done4 && l4 == 0) begin l4 = c; h4 = hi4; g4 = lo4; end
      if (l1 != 0 && l4 != 0) break;
    end
    check("step1_lat", 32'(l1), 32'd34);
    check("step1_hi", h1, 32'hFFFF_FFFE);
    check("step1_lo", g1, 32'h0000_0001);
    check("step4_lat", 32'(l4), 32'd10);
    check("step4_hi", h4, 32'hFFFF_FFFE);
    check("step4_lo", g4, 32'h0000_0001);
    check("step1_ready", {31'b0, ready1}, 32'd1);
    check("step4_idle", {30'b0, busy4, dz4}, 32'd0);
    check("step1_dz", {30'b0, busy1, dz1}, 32'd0);
    $display("txn step1/step4 MULTU ffffffff*ffffffff lat1=%0d lat4=%0d hi1=%h lo1=%h hi4=%h lo4=%h",
             l1, l4, h1, g1, h4, g4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int dcyc;
    logic [31:0] gh, gl;

    #22 rst = 1'b0;
    @(negedge clk);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_dz", {31'b0, dz}, 32'd0);

    run("mult_m3x7",    2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 18);
    run("multu_ones",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 18);
    run("mult_minsq",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 18);
    run("div_m7d2",     2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
    run("divu_min3",    2'b11, 32'h8000_0000, 32'h0000_0003, 32'h0000_0002, 32'h2AAA_AAAA, 1'b0, 34);
    run("div_7dm2",     2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34);
    run("div_m8dm3",    2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, 1'b0, 34);
    run("divu_5dones",  2'b11, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0000, 1'b0, 34);
    run("div_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 2);
    run("divu_zero",    2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 2);
    repeat (3) @(negedge clk);
    check("dz_sticky", {31'b0, dz}, 32'd1);
    run("mult_5x6",     2'b00, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 32'h0000_001E, 1'b0, 18);
    run("div_zero_s",   2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 2);

    // A start while a divide is in flight is ignored
    nd = 0; dcyc = 0; gh = '0; gl = '0;
    start_op(2'b10, 32'd100, 32'd7);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 5) begin start = 1'b1; op = 2'b00; op1 = 32'd3; op2 = 32'd3; end
      if (c == 6) start = 1'b0;
      if (done) begin
        nd++;
        if (nd == 1) begin dcyc = c; gh = hi; gl = lo; end
      end
    end
    check("ign_done_count", 32'(nd), 32'd1);
    check("ign_lat", 32'(dcyc), 32'd34);
    check("ign_hi", gh, 32'd2);
    check("ign_lo", gl, 32'd14);
    $display("txn ignored_start div 100/7 -> hi=%h lo=%h done_pulses=%0d", gh, gl, nd);

    // Flush mid-divide: back to idle, HI/LO untouched, no done
    start_op(2'b11, 32'd1000, 32'd3);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", {31'b0, ready}, 32'd1);
    check("flush_hi", hi, 32'd2);
    check("flush_lo", lo, 32'd14);
    check("flush_done", {31'b0, done}, 32'd0);
    nd = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("flush_no_done", 32'(nd), 32'd0);
    $display("txn flush divu 1000/3 at iteration 10 -> hi=%h lo=%h done_pulses=%0d", hi, lo, nd);

    // Flush and start together in idle: start dropped
    start_op(2'b00, 32'd2, 32'd2);
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("fs_busy", {31'b0, busy}, 32'd0);
    nd = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("fs_no_done", 32'(nd), 32'd0);
    check("fs_lo", lo, 32'd14);
    $display("txn flush+start idle -> dropped, done_pulses=%0d", nd);

    // Back-to-back: second start issued in the done cycle of the first
    run("b2b_multu_3x4", 2'b01, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 18);
    run("b2b_mult_m1sq", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'd1, 1'b0, 18);

    aux_run();

    // Asynchronous reset between edges during a multiply
    @(negedge clk);
    run("mult_pre_rst", 2'b00, 32'h0001_0000, 32'h0001_0001, 32'h0000_0001, 32'h0001_0000, 1'b0, 18);
    start_op(2'b00, 32'h1234, 32'h10);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_hi", hi, 32'h0);
    check("arst_lo", lo, 32'h0);
    check("arst_ready", {31'b0, ready}, 32'd1);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_dz", {31'b0, dz}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    run("mult_5x6_post", 2'b00, 32'd5, 32'd6, 32'h0, 32'd30, 1'b0, 18);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
